// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle accumulator CPU core.
//   Instruction memory (loadable through we_im_i), paired-operand data memory,
//   A/B/C registers, ALU, PC and an IDLE/FETCH/EXEC/MEM/HALTED controller.
// Optional feature macro: CPU_MUL_EN (adds the A*B multiplier for opcode 4;
//   without it opcode 4 behaves as NOP).
// Parameters:
//   DATA_W      width of A and B; C and data-memory words are 2*DATA_W
//   ADDR_W      PC / IM / DM address width, must not exceed DATA_W
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   en_i        run enable
//   we_im_i     instruction-memory write strobe
//   im_waddr_i  instruction-memory write address
//   code_i      instruction word {opcode[3:0], operand[ADDR_W-1:0]}
//   pc_o        current PC (registered)
//   c_o         register C (registered)
//   halted_o    core is in HALTED (registered)
//   z_a_o, z_b_o, a_bigger_o, b_bigger_o, eq_o
//               unsigned compare flags derived from registers A and B
module cpu_core_param #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 12
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic                we_im_i,
   input  logic [ADDR_W-1:0]   im_waddr_i,
   input  logic [ADDR_W+3:0]   code_i,
   output logic [ADDR_W-1:0]   pc_o,
   output logic [2*DATA_W-1:0] c_o,
   output logic                halted_o,
   output logic                z_a_o,
   output logic                z_b_o,
   output logic                a_bigger_o,
   output logic                b_bigger_o,
   output logic                eq_o
);

   localparam int unsigned CW    = 2 * DATA_W;
   localparam int unsigned IW    = 4 + ADDR_W;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDAB = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_MUL  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_STC  = 4'h8;
   localparam logic [3:0] OP_LDC  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JEQ  = 4'hB;
   localparam logic [3:0] OP_JGT  = 4'hC;
   localparam logic [3:0] OP_LDH  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALTED
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [IW-1:0]     ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [CW-1:0]     c_q, c_d;
   logic              halted_q, halted_d;
   logic [CW-1:0]     dm_rd_q;
   logic              dm_we_c;
   logic              dm_re_c;

   logic [IW-1:0]     im [DEPTH];
   logic [CW-1:0]     dm [DEPTH];

   logic [3:0]        op;
   logic [ADDR_W-1:0] opnd;
   logic [CW-1:0]     a_ext;
   logic [CW-1:0]     b_ext;

   assign op    = ir_q[IW-1 -: 4];
   assign opnd  = ir_q[ADDR_W-1:0];
   assign a_ext = CW'(a_q);
   assign b_ext = CW'(b_q);

   // Status flags straight from A/B
   assign z_a_o      = (a_q == '0);
   assign z_b_o      = (b_q == '0);
   assign a_bigger_o = (a_q > b_q);
   assign b_bigger_o = (b_q > a_q);
   assign eq_o       = (a_q == b_q);

   assign pc_o     = pc_q;
   assign c_o      = c_q;
   assign halted_o = halted_q;

   // Instruction memory: write port from the loader; fetch sees the pre-write word
   always_ff @(posedge clk_i) begin
      if (we_im_i) begin
         im[im_waddr_i] <= code_i;
      end
   end

   // Data memory: STC writes, LDAB read registered at the end of EXEC
   always_ff @(posedge clk_i) begin
      if (dm_we_c) begin
         dm[opnd] <= c_q;
      end
      if (dm_re_c) begin
         dm_rd_q <= dm[opnd];
      end
   end

   // State and architectural registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         halted_q <= halted_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      halted_d = halted_q;
      dm_we_c  = 1'b0;
      dm_re_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en_i) begin
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            ir_d    = im[pc_q];
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_EXEC;
         end

         S_EXEC: begin
            state_d = en_i ? S_FETCH : S_IDLE;
            case (op)
               OP_NOP:  ;
               OP_LDAB: begin
                  dm_re_c = 1'b1;
                  state_d = S_MEM;
               end
               OP_ADD:  c_d = a_ext + b_ext;
               OP_SUB:  c_d = a_ext - b_ext;
`ifdef CPU_MUL_EN
               OP_MUL:  c_d = a_ext * b_ext;
`else
               OP_MUL:  ;
`endif
               OP_AND:  c_d = a_ext & b_ext;
               OP_OR:   c_d = a_ext | b_ext;
               OP_XOR:  c_d = a_ext ^ b_ext;
               OP_STC:  dm_we_c = 1'b1;
               OP_LDC:  c_d = CW'(opnd);
               OP_JMP:  pc_d = opnd;
               OP_JEQ:  if (eq_o) pc_d = opnd;
               OP_JGT:  if (a_bigger_o) pc_d = opnd;
               // ADDR_W <= DATA_W keeps the operand within the upper half
               OP_LDH:  c_d = {DATA_W'(opnd), c_q[DATA_W-1:0]};
               OP_HALT: begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end
               default: ;
            endcase
         end

         S_MEM: begin
            a_d     = dm_rd_q[DATA_W-1:0];
            b_d     = dm_rd_q[CW-1:DATA_W];
            state_d = en_i ? S_FETCH : S_IDLE;
         end

         S_HALTED: begin
            // Dropping enable releases the halt and restarts from address 0
            if (!en_i) begin
               state_d  = S_IDLE;
               pc_d     = '0;
               halted_d = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param: directed programs, expectations queued with the
// cycle at which they apply; a negedge monitor pops and compares them.
module tb_cpu_core_param;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 12;

   localparam logic [4:0] F_ZERO = 5'b11001; // {z_a, z_b, a_bigger, b_bigger, eq}
   localparam logic [4:0] F_AGT  = 5'b00100;
   localparam logic [4:0] F_BGT  = 5'b00010;
   localparam logic [4:0] F_EQ   = 5'b00001;
   localparam logic [4:0] F_AGTZ = 5'b01100;

`ifdef CPU_MUL_EN
   localparam logic [31:0] MUL_EXP = 32'h0012_3400;
`else
   localparam logic [31:0] MUL_EXP = 32'h0100_1234;
`endif

   logic        clk_i;
   logic        rst_n_i;
   logic        en_i;
   logic        we_im_i;
   logic [11:0] im_waddr_i;
   logic [15:0] code_i;
   logic [11:0] pc_o;
   logic [31:0] c_o;
   logic        halted_o;
   logic        z_a_o, z_b_o, a_bigger_o, b_bigger_o, eq_o;

   cpu_core_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .en_i       (en_i),
      .we_im_i    (we_im_i),
      .im_waddr_i (im_waddr_i),
      .code_i     (code_i),
      .pc_o       (pc_o),
      .c_o        (c_o),
      .halted_o   (halted_o),
      .z_a_o      (z_a_o),
      .z_b_o      (z_b_o),
      .a_bigger_o (a_bigger_o),
      .b_bigger_o (b_bigger_o),
      .eq_o       (eq_o)
   );

   typedef struct {
      int          cyc;
      string       name;
      logic [11:0] pc;
      logic [31:0] c;
      logic        halted;
      logic [4:0]  flags;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] n);
      return {op, n};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Monitor: compare every expectation that is due at this negedge
   always @(negedge clk_i) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk({e.name, ".pc"},     32'(pc_o),     32'(e.pc));
         chk({e.name, ".c"},      c_o,           e.c);
         chk({e.name, ".halted"}, 32'(halted_o), 32'(e.halted));
         chk({e.name, ".flags"},
             32'({z_a_o, z_b_o, a_bigger_o, b_bigger_o, eq_o}), 32'(e.flags));
      end
   end

   task automatic expect_at(input int at, input string nm, input logic [11:0] pc,
                            input logic [31:0] c, input logic h, input logic [4:0] fl);
      exp_t e;
      e.cyc = at; e.name = nm; e.pc = pc; e.c = c; e.halted = h; e.flags = fl;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk_i);
   endtask

   task automatic load(input logic [11:0] addr, input logic [15:0] word);
      @(negedge clk_i);
      we_im_i    = 1'b1;
      im_waddr_i = addr;
      code_i     = word;
      @(negedge clk_i);
      we_im_i    = 1'b0;
   endtask

   // Start running; returns the cycle index at which en_i was raised
   task automatic start(output int k);
      @(negedge clk_i);
      en_i = 1'b1;
      k    = cyc;
   endtask

   // Drop enable once halted and let the core return to IDLE
   task automatic park(input int at);
      wait_until(at);
      en_i = 1'b0;
      wait_until(at + 2);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int k, j;
      rst_n_i = 1'b0; en_i = 1'b0; we_im_i = 1'b0; im_waddr_i = '0; code_i = '0;
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      k = cyc;
      expect_at(k + 1, "reset", 12'h000, 32'h0, 1'b0, F_ZERO);
      wait_until(k + 2);

      // Main program: A=7, B=3, C=10, halt 16 edges after enable
      load(12'h000, ins(4'h9, 12'h007));
      load(12'h001, ins(4'hD, 12'h003));
      load(12'h002, ins(4'h8, 12'h020));
      load(12'h003, ins(4'h1, 12'h020));
      load(12'h004, ins(4'h2, 12'h000));
      load(12'h005, ins(4'h8, 12'h021));
      load(12'h006, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 3,  "ldc",      12'h001, 32'h0000_0007, 1'b0, F_ZERO);
      expect_at(k + 5,  "ldh",      12'h002, 32'h0003_0007, 1'b0, F_ZERO);
      expect_at(k + 10, "ldab",     12'h004, 32'h0003_0007, 1'b0, F_AGT);
      expect_at(k + 15, "pre_halt", 12'h007, 32'h0000_000A, 1'b0, F_AGT);
      expect_at(k + 16, "halt",     12'h007, 32'h0000_000A, 1'b1, F_AGT);
      expect_at(k + 18, "hold",     12'h007, 32'h0000_000A, 1'b1, F_AGT);
      expect_at(k + 19, "unhalt",   12'h000, 32'h0000_000A, 1'b0, F_AGT);
      park(k + 18);

      // STC 0x021 stored C=10: read it back as A=10, B=0
      load(12'h000, ins(4'h1, 12'h021));
      load(12'h001, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 4, "stc_rb",   12'h001, 32'h0000_000A, 1'b0, F_AGTZ);
      expect_at(k + 6, "stc_halt", 12'h002, 32'h0000_000A, 1'b1, F_AGTZ);
      park(k + 6);

      // JEQ at 0x005 with A=B=4: taken to 0x009
      load(12'h000, ins(4'h9, 12'h004));
      load(12'h001, ins(4'hD, 12'h004));
      load(12'h002, ins(4'h8, 12'h040));
      load(12'h003, ins(4'h1, 12'h040));
      load(12'h004, ins(4'h0, 12'h000));
      load(12'h005, ins(4'hB, 12'h009));
      load(12'h006, ins(4'hF, 12'h000));
      load(12'h007, ins(4'hF, 12'h000));
      load(12'h008, ins(4'hF, 12'h000));
      load(12'h009, ins(4'h9, 12'h099));
      load(12'h00A, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 13, "jeq_fetch", 12'h006, 32'h0004_0004, 1'b0, F_EQ);
      expect_at(k + 14, "jeq_taken", 12'h009, 32'h0004_0004, 1'b0, F_EQ);
      expect_at(k + 18, "jeq_halt",  12'h00B, 32'h0000_0099, 1'b1, F_EQ);
      park(k + 18);

      // Same loop with B=2: not taken
      load(12'h001, ins(4'hD, 12'h002));
      start(k);
      expect_at(k + 14, "jeq_not",     12'h006, 32'h0002_0004, 1'b0, F_AGT);
      expect_at(k + 16, "jeq_nt_halt", 12'h007, 32'h0002_0004, 1'b1, F_AGT);
      park(k + 16);

      // SUB wrap: 2 - 5
      load(12'h000, ins(4'h9, 12'h002));
      load(12'h001, ins(4'hD, 12'h005));
      load(12'h002, ins(4'h8, 12'h050));
      load(12'h003, ins(4'h1, 12'h050));
      load(12'h004, ins(4'h3, 12'h000));
      load(12'h005, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 12, "sub_wrap", 12'h005, 32'hFFFF_FFFD, 1'b0, F_BGT);
      expect_at(k + 14, "sub_halt", 12'h006, 32'hFFFF_FFFD, 1'b1, F_BGT);
      park(k + 14);

      // MUL: build A=0x1234 via ADD, B=0x0100 via LDH
      load(12'h000, ins(4'h9, 12'hFFF));
      load(12'h001, ins(4'hD, 12'h235));
      load(12'h002, ins(4'h8, 12'h060));
      load(12'h003, ins(4'h1, 12'h060));
      load(12'h004, ins(4'h2, 12'h000));
      load(12'h005, ins(4'hD, 12'h100));
      load(12'h006, ins(4'h8, 12'h061));
      load(12'h007, ins(4'h1, 12'h061));
      load(12'h008, ins(4'h4, 12'h000));
      load(12'h009, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 12, "mul_add",  12'h005, 32'h0000_1234, 1'b0, F_AGT);
      expect_at(k + 14, "mul_ldh",  12'h006, 32'h0100_1234, 1'b0, F_AGT);
      expect_at(k + 19, "mul_ldab", 12'h008, 32'h0100_1234, 1'b0, F_AGT);
      expect_at(k + 21, "mul",      12'h009, MUL_EXP,       1'b0, F_AGT);
      expect_at(k + 23, "mul_halt", 12'h00A, MUL_EXP,       1'b1, F_AGT);
      park(k + 23);

      // Enable dropped during LDAB's MEM cycle, then IM write/fetch collision
      load(12'h000, ins(4'h9, 12'h009));
      load(12'h001, ins(4'hD, 12'h006));
      load(12'h002, ins(4'h8, 12'h070));
      load(12'h003, ins(4'h1, 12'h070));
      load(12'h004, ins(4'h9, 12'h055));
      load(12'h005, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 10, "mem_drop", 12'h004, 32'h0006_0009, 1'b0, F_AGT);
      expect_at(k + 12, "parked",   12'h004, 32'h0006_0009, 1'b0, F_AGT);
      wait_until(k + 9);
      en_i = 1'b0;
      wait_until(k + 12);
      en_i = 1'b1;
      j = cyc;
      expect_at(j + 3, "old_word",  12'h005, 32'h0000_0055, 1'b0, F_AGT);
      expect_at(j + 5, "coll_halt", 12'h006, 32'h0000_0055, 1'b1, F_AGT);
      wait_until(j + 1);
      we_im_i = 1'b1; im_waddr_i = 12'h004; code_i = ins(4'h9, 12'h0AA);
      wait_until(j + 2);
      we_im_i = 1'b0;
      park(j + 5);
      start(k);
      expect_at(k + 12, "new_word", 12'h005, 32'h0000_00AA, 1'b0, F_AGT);
      expect_at(k + 14, "new_halt", 12'h006, 32'h0000_00AA, 1'b1, F_AGT);
      park(k + 14);

      // Reset in EXEC of ADD (A=5, B=3)
      load(12'h000, ins(4'h9, 12'h005));
      load(12'h001, ins(4'hD, 12'h003));
      load(12'h002, ins(4'h8, 12'h030));
      load(12'h003, ins(4'h1, 12'h030));
      load(12'h004, ins(4'h2, 12'h000));
      load(12'h005, ins(4'hF, 12'h000));
      start(k);
      expect_at(k + 11, "add_exec", 12'h005, 32'h0003_0005, 1'b0, F_AGT);
      expect_at(k + 12, "rst_mid",  12'h000, 32'h0,         1'b0, F_ZERO);
      expect_at(k + 13, "rst_idle", 12'h000, 32'h0,         1'b0, F_ZERO);
      wait_until(k + 11);
      #2;
      rst_n_i = 1'b0;
      en_i    = 1'b0;
      wait_until(k + 12);
      #2;
      rst_n_i = 1'b1;
      wait_until(k + 14);

      // DM[0x030] and IM[0x005] (HALT) survive reset
      load(12'h000, ins(4'h1, 12'h030));
      load(12'h001, ins(4'h2, 12'h000));
      load(12'h002, ins(4'hA, 12'h005));
      start(k);
      expect_at(k + 4,  "ret_ldab", 12'h001, 32'h0,         1'b0, F_AGT);
      expect_at(k + 6,  "ret_add",  12'h002, 32'h0000_0008, 1'b0, F_AGT);
      expect_at(k + 8,  "ret_jmp",  12'h005, 32'h0000_0008, 1'b0, F_AGT);
      expect_at(k + 10, "ret_halt", 12'h006, 32'h0000_0008, 1'b1, F_AGT);
      park(k + 10);

      wait_until(cyc + 2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
